// File: rtl/uart_alu_parser.sv
// UART byte-stream to ALU command parser.
// Collects opcode + two little-endian 32-bit operands and drops stalled packets.
module uart_alu_parser #(
  parameter int unsigned TimeoutCycles = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [1:0]  opcode_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  input  logic        ready_i,
  output logic        timeout_o
);

  localparam int unsigned IdleW =
    (TimeoutCycles == 0) ? 1 : $clog2(TimeoutCycles + 1);
  localparam bit TimeoutEn = (TimeoutCycles != 0);
  localparam logic [IdleW-1:0] IdleLast =
    IdleW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    StOpcode,
    StOperandA,
    StOperandB,
    StIssue
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        opcode_q, opcode_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic              accept;
  logic              idle_hit;
  logic [1:0]        op_dec;

  assign ready_o     = (state_q != StIssue) && !reset_i;
  assign valid_o     = (state_q == StIssue);
  assign timeout_o   = timeout_q;
  assign opcode_o    = opcode_q;
  assign operand_a_o = a_q;
  assign operand_b_o = b_q;

  assign accept   = valid_i && ready_o;
  assign idle_hit = TimeoutEn && (idle_q == IdleLast);

  // Map the received opcode byte onto the ALU opcode.
  always_comb begin
    op_dec = 2'b00;
    case (data_i)
      8'h10:   op_dec = 2'b01;
      8'h11:   op_dec = 2'b10;
      8'h12:   op_dec = 2'b11;
      default: op_dec = 2'b00;
    endcase
  end

  // Next-state, byte capture and idle-timeout decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idle_d    = idle_q;
    timeout_d = 1'b0;
    opcode_d  = opcode_q;
    a_d       = a_q;
    b_d       = b_q;
    unique case (state_q)
      StOpcode: begin
        idle_d = '0;
        if (accept) begin
          opcode_d = op_dec;
          cnt_d    = 2'd0;
          state_d  = StOperandA;
        end
      end
      StOperandA: begin
        if (accept) begin
          a_d[{cnt_q, 3'b000} +: 8] = data_i;
          idle_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StOperandB;
        end else if (idle_hit) begin
          state_d   = StOpcode;
          cnt_d     = 2'd0;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StOperandB: begin
        if (accept) begin
          b_d[{cnt_q, 3'b000} +: 8] = data_i;
          idle_d = '0;
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StIssue;
        end else if (idle_hit) begin
          state_d   = StOpcode;
          cnt_d     = 2'd0;
          idle_d    = '0;
          timeout_d = 1'b1;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      StIssue: begin
        idle_d = '0;
        if (ready_i) state_d = StOpcode;
      end
      default: state_d = StOpcode;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StOpcode;
      cnt_q     <= 2'd0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
      opcode_q  <= 2'b00;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
      opcode_q  <= opcode_d;
      a_q       <= a_d;
      b_q       <= b_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_parser.sv
// Bench for uart_alu_parser: vector table, corner sequences,
// and random traffic against a packet-level reference model.
module tb_uart_alu_parser;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic [7:0]  data_i;
  logic        ready_o;
  logic        valid_o;
  logic [1:0]  opcode_o;
  logic [31:0] operand_a_o;
  logic [31:0] operand_b_o;
  logic        ready_i;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  uart_alu_parser #(.TimeoutCycles(TO)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .ready_o     (ready_o),
    .valid_o     (valid_o),
    .opcode_o    (opcode_o),
    .operand_a_o (operand_a_o),
    .operand_b_o (operand_b_o),
    .ready_i     (ready_i),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] pkt;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    chk("byte_ready", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    data_i  = b;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [71:0] p);
    for (int i = 0; i < 9; i++) begin
      logic [7:0] b;
      b = p[71-8*i -: 8];
      send_byte(b);
    end
  endtask

  task automatic chk_cmd(input string nm, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    chk({nm, "_valid"}, 32'(valid_o), 32'd1);
    chk({nm, "_op"}, 32'(opcode_o), 32'(op));
    chk({nm, "_a"}, operand_a_o, a);
    chk({nm, "_b"}, operand_b_o, b);
  endtask

  function automatic logic [1:0] dec(input logic [7:0] b);
    if (b == 8'h10) return 2'b01;
    if (b == 8'h11) return 2'b10;
    if (b == 8'h12) return 2'b11;
    return 2'b00;
  endfunction

  logic [7:0]  q[$];
  logic        pend;
  logic [1:0]  pop;
  logic [31:0] pa, pb;
  int          idle;
  logic        mto;
  int          pulses, pulse_at, vseen;
  bit          quiet;

  initial begin
    vecs[0] = '{72'h10_01000000_02000000, 2'b01, 32'h00000001, 32'h00000002};
    vecs[1] = '{72'h7F_01020304_05060708, 2'b00, 32'h04030201, 32'h08070605};
    vecs[2] = '{72'h12_FFFFFFFF_00000000, 2'b11, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{72'h11_78563412_EFBEADDE, 2'b10, 32'h12345678, 32'hDEADBEEF};
    vecs[4] = '{72'h00_AA000000_000000BB, 2'b00, 32'h000000AA, 32'hBB000000};
    vecs[5] = '{72'h13_11223344_55667788, 2'b00, 32'h44332211, 32'h88776655};

    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    ready_i = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_op", 32'(opcode_o), 32'd0);
    chk("rst_a", operand_a_o, 32'd0);
    chk("rst_b", operand_b_o, 32'd0);
    reset_i = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ready_o), 32'd1);

    // Table: back-to-back packets with ALU always ready.
    for (int v = 0; v < 6; v++) begin
      ready_i = 1'b1;
      send_pkt(vecs[v].pkt);
      chk_cmd("vec", vecs[v].op, vecs[v].a, vecs[v].b);
      chk("vec_ready_issue", 32'(ready_o), 32'd0);
      tick();
      chk("vec_done_valid", 32'(valid_o), 32'd0);
      chk("vec_done_ready", 32'(ready_o), 32'd1);
    end

    // ALU stalls 5 cycles; junk bytes offered must be ignored.
    ready_i = 1'b0;
    send_pkt(72'h11_78563412_EFBEADDE);
    for (int k = 0; k < 5; k++) begin
      chk_cmd("hold", 2'b10, 32'h12345678, 32'hDEADBEEF);
      chk("hold_ready", 32'(ready_o), 32'd0);
      valid_i = 1'b1;
      data_i  = 8'h55;
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk_cmd("hold_last", 2'b10, 32'h12345678, 32'hDEADBEEF);
    tick();
    chk("hold_done_valid", 32'(valid_o), 32'd0);
    chk("hold_done_ready", 32'(ready_o), 32'd1);
    send_pkt(vecs[0].pkt);
    chk_cmd("after_hold", 2'b01, 32'h1, 32'h2);
    tick();

    // Timeout after 8 idle cycles mid-packet.
    send_byte(8'h10);
    send_byte(8'hAA);
    pulses = 0;
    pulse_at = 0;
    vseen = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (timeout_o) begin
        pulses++;
        pulse_at = i;
      end
      if (valid_o) vseen++;
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_pulse_at", 32'(pulse_at), 32'd8);
    chk("to_no_valid", 32'(vseen), 32'd0);
    send_pkt(vecs[2].pkt);
    chk_cmd("after_to", 2'b11, 32'hFFFFFFFF, 32'h0);
    tick();

    // Seven idle cycles then a byte: acceptance wins, no timeout.
    send_byte(8'h10);
    send_byte(8'hAA);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (timeout_o) pulses++;
    end
    for (int i = 0; i < 7; i++) begin
      logic [55:0] rest;
      rest = 56'hBB_CC_DD_01_02_03_04;
      send_byte(rest[55-8*i -: 8]);
      if (timeout_o) pulses++;
    end
    chk("nto_pulses", 32'(pulses), 32'd0);
    chk_cmd("nto", 2'b01, 32'hDDCCBBAA, 32'h04030201);
    tick();

    // Reset after 5 bytes of a packet.
    for (int i = 0; i < 5; i++) send_byte(vecs[5].pkt[71-8*i -: 8]);
    reset_i = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'd0);
    tick();
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_op", 32'(opcode_o), 32'd0);
    chk("midrst_a", operand_a_o, 32'd0);
    chk("midrst_b", operand_b_o, 32'd0);
    chk("midrst_to", 32'(timeout_o), 32'd0);
    reset_i = 1'b0;
    vseen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (valid_o) vseen++;
    end
    chk("midrst_no_issue", 32'(vseen), 32'd0);
    send_pkt(vecs[3].pkt);
    chk_cmd("after_midrst", 2'b10, 32'h12345678, 32'hDEADBEEF);
    tick();

    // Reset while a command is waiting in Issue.
    ready_i = 1'b0;
    send_pkt(vecs[1].pkt);
    chk("issrst_pre", 32'(valid_o), 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    ready_i = 1'b1;
    vseen = 0;
    for (int i = 0; i < 3; i++) begin
      if (valid_o) vseen++;
      tick();
    end
    chk("issrst_no_issue", 32'(vseen), 32'd0);

    // Random traffic against the packet model.
    q.delete();
    pend = 1'b0;
    pop = 2'b00;
    pa = 32'd0;
    pb = 32'd0;
    idle = 0;
    mto = 1'b0;
    quiet = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic acc;
      if (c % 60 == 0) quiet = ($urandom_range(0, 2) == 0);
      valid_i = quiet ? ($urandom_range(0, 99) < 3)
                      : ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 1) == 1)
        data_i = 8'h10 + 8'($urandom_range(0, 3));
      else
        data_i = 8'($urandom);
      ready_i = ($urandom_range(0, 99) < 60);
      chk("rnd_ready", 32'(ready_o), 32'(!pend));
      chk("rnd_valid", 32'(valid_o), 32'(pend));
      chk("rnd_timeout", 32'(timeout_o), 32'(mto));
      if (pend && valid_o) begin
        chk("rnd_op", 32'(opcode_o), 32'(pop));
        chk("rnd_a", operand_a_o, pa);
        chk("rnd_b", operand_b_o, pb);
      end
      acc = valid_i && !pend;
      mto = 1'b0;
      if (pend) begin
        if (ready_i) pend = 1'b0;
      end else if (acc) begin
        q.push_back(data_i);
        idle = 0;
        if (q.size() == 9) begin
          pop  = dec(q[0]);
          pa   = {q[4], q[3], q[2], q[1]};
          pb   = {q[8], q[7], q[6], q[5]};
          pend = 1'b1;
          q.delete();
        end
      end else if (q.size() > 1) begin
        idle++;
        if (idle == TO) begin
          q.delete();
          idle = 0;
          mto  = 1'b1;
        end
      end else if (q.size() == 1) begin
        idle++;
        if (idle == TO) begin
          q.delete();
          idle = 0;
          mto  = 1'b1;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_alu_parser.md
UART_ALU_PARSER -- requirements
Module: uart_alu_parser

Interface
REQ-001 Parameter TimeoutCycles, default 100000, is the number of consecutive idle cycles mid-packet before the partial packet is dropped; 0 disables the timeout.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_i  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  upstream UART receive byte is valid.
REQ-005 data_i  input  8  received byte.
REQ-006 ready_o  output  1  parser can accept a byte this cycle.
REQ-007 valid_o  output  1  complete command presented to the ALU.
REQ-008 opcode_o  output  2  ALU opcode: 2'b00 Nop, 2'b01 Add, 2'b10 Multiply, 2'b11 Divide.
REQ-009 operand_a_o  output  32  operand A.
REQ-010 operand_b_o  output  32  operand B.
REQ-011 ready_i  input  1  ALU accepts the command this cycle.
REQ-012 timeout_o  output  1  one-cycle pulse when a partial packet is dropped.

Function
REQ-013 Byte accepted only in a cycle with valid_i && ready_o.
REQ-014 Packet is fixed at 9 bytes: opcode byte, 4 bytes operand A, 4 bytes operand B; operands little-endian (first byte -> bits [7:0]).
REQ-015 Opcode map: 0x10 -> Add, 0x11 -> Multiply, 0x12 -> Divide, any other value -> Nop; a Nop packet still consumes 8 operand bytes and is issued.
REQ-016 FSM states: Opcode, OperandA, OperandB, Issue; byte counter 0..3 within each operand state.
REQ-017 Transitions: Opcode -> OperandA on an accepted byte; OperandA -> OperandB on the 4th accepted A byte; OperandB -> Issue on the 4th accepted B byte; Issue -> Opcode on valid_o && ready_i.
REQ-018 ready_o = 1 in Opcode, OperandA and OperandB; 0 in Issue and while reset_i is high.
REQ-019 valid_o = 1 exactly in Issue; asserts the cycle after the 9th byte is accepted (latency 1).
REQ-020 While valid_o && !ready_i, opcode_o, operand_a_o and operand_b_o hold stable; no byte is accepted.
REQ-021 After transfer, ready_o = 1 and valid_o = 0 on the next cycle; back-to-back packets therefore issue no closer than 10 cycles apart.
REQ-022 Operand bytes are written directly into the output registers as accepted; the opcode register is written on opcode acceptance; outputs are don't-care whenever valid_o = 0.
REQ-023 Idle counter runs only in OperandA/OperandB: cleared on each accepted byte and on entry to OperandA, incremented in each cycle with no acceptance.
REQ-024 When TimeoutCycles consecutive idle cycles elapse (TimeoutCycles != 0), the next state is Opcode, the byte counter clears, and timeout_o pulses for 1 cycle; the partial packet is never issued.
REQ-025 A byte accepted in the cycle the counter would reach its limit clears the counter; acceptance wins, no timeout.
REQ-026 No timeout in Opcode or Issue, regardless of how long valid_o waits for ready_i.
REQ-027 Idle counter width is $clog2(TimeoutCycles+1), minimum 1 bit.

Reset
REQ-028 While reset_i = 1: state Opcode, byte counter 0, idle counter 0, valid_o 0, timeout_o 0, opcode_o 2'b00, operand_a_o 0, operand_b_o 0.
REQ-029 Reset asserted mid-packet or in Issue discards the packet; no command is issued for it after reset is released.
REQ-030 First byte can be accepted the first cycle after reset_i deasserts.

Verification
REQ-031 Bytes 10 01 00 00 00 02 00 00 00 sent back-to-back, ready_i = 1 -> one cycle after the 9th byte: valid_o = 1, opcode_o = 01, operand_a_o = 0x00000001, operand_b_o = 0x00000002; next cycle ready_o = 1.
REQ-032 Bytes 11 78 56 34 12 EF BE AD DE with ready_i = 0 for 5 cycles -> valid_o held 5 cycles, opcode_o = 10, A = 0x12345678, B = 0xDEADBEEF stable, ready_o = 0; transfer on the cycle ready_i = 1.
REQ-033 Opcode byte 0x7F plus 8 operand bytes -> issued with opcode_o = 00; opcode 0x12 -> opcode_o = 11.
REQ-034 TimeoutCycles = 8: send 10 AA, then idle 8 cycles -> timeout_o pulses once, no valid_o; a following full packet decodes correctly. Idle 7 cycles, then a byte -> no timeout.
REQ-035 Reset pulsed after 5 bytes of a packet -> all outputs zero and no valid_o; a new 9-byte packet issues correctly.
